seq_alu: RTL and testbench

- Parametrised, clocked successor to the switch-driven combinational calculator ALU on the Basys3 board.
- Performs add, subtract, divide and multiply on two WIDTH-bit unsigned operands.
- Operation is chosen by the same left-to-right priority over four op-select bits.
- Add/sub complete in one cycle. Multiply (shift-add) and divide (restoring) are iterative, take WIDTH cycles, and use a start/busy/done handshake.
- Sits between debounced switch/button logic and the seven-segment/LED display driver.

---
 rtl/seq_alu_pkg.sv | 32 +++
 rtl/seq_divider.sv | 73 +++++++
 rtl/seq_alu.sv | 181 ++++++++++++++++++
 tb/tb_seq_alu.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// ----------------------------------------------------------------------------
// seq_alu_pkg
// Shared types for the sequential calculator ALU: operation encoding, FSM
// state encoding and the op_sel priority encoder.
// ----------------------------------------------------------------------------
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_DIV  = 3'd2,
        OP_MUL  = 3'd3,
        OP_NONE = 3'd4
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Left-to-right priority: bit3 add, bit2 sub, bit1 div, bit0 mul.
    function automatic op_t encode_op(input logic [3:0] op_sel);
        op_t op;
        op = OP_NONE;
        if (op_sel[3])      op = OP_ADD;
        else if (op_sel[2]) op = OP_SUB;
        else if (op_sel[1]) op = OP_DIV;
        else if (op_sel[0]) op = OP_MUL;
        return op;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Restoring unsigned divider, one quotient bit per step.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   load            capture dividend/divisor, clear partial remainder
//   step            perform one restoring iteration
//   dividend        WIDTH-bit dividend
//   divisor         WIDTH-bit divisor
//   quotient        quotient value as it will be after the current step
//   remainder       remainder as it will be after the current step
//                   (present only when SEQ_ALU_REMAINDER_EN is defined)
//
// The outputs are the combinational result of the step in progress so the
// controller can commit the final value on the same edge as the last step.
// With divisor==0 every trial subtraction succeeds: quotient becomes all ones
// and the remainder ends up equal to the dividend.
// ----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient
`ifdef SEQ_ALU_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] remainder
`endif
);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;

    // Dividend bits shift out of the top of quo_q into the partial remainder
    // while quotient bits shift in at the bottom.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        fits     = (shifted >= {1'b0, dvs_q});
        quo_next = {quo_q[WIDTH-2:0], fits};
        rem_next = fits ? WIDTH'(shifted - {1'b0, dvs_q}) : WIDTH'(shifted);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            quo_q <= quo_next;
            rem_q <= rem_next;
        end
    end

    assign quotient = quo_next;
`ifdef SEQ_ALU_REMAINDER_EN
    assign remainder = rem_next;
`endif

endmodule

// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu
// Clocked calculator ALU: add/sub in one CALC cycle, shift-add multiply and
// restoring divide in WIDTH CALC cycles, start/busy/done handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      request, sampled only in IDLE
//   op_sel     [3:0] bit3 add, bit2 sub, bit1 div, bit0 mul (priority 3>2>1>0)
//   x, y       WIDTH-bit unsigned operands (dividend/minuend, divisor/subtrahend)
//   result     RES_W-bit last completed result, held until the next done
//   busy       high while in CALC
//   done       one-cycle pulse when result updates
//   div_zero   divide with y==0 (set with done, cleared on accepted start)
//   neg        negative subtract result (set with done, cleared on accepted start)
//   remainder  WIDTH-bit divide remainder, only with SEQ_ALU_REMAINDER_EN
//
// Optional feature macro: SEQ_ALU_REMAINDER_EN
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; result and flags hold the last completed op
// CALC  | operation in progress; cnt counts down, result commits at cnt==1
// ----------------------------------------------------------------------------
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int RES_W = 2*WIDTH+1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op_sel,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [RES_W-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             neg
`ifdef SEQ_ALU_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] remainder
`endif
);

    localparam int CNT_W = $clog2(WIDTH+1);

    state_t             state;
    state_t             state_next;
    op_t                op_q;
    op_t                op_start;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   y_q;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod_step;

    logic [WIDTH-1:0]   quo_step;
    logic [RES_W-1:0]   res_final;
`ifdef SEQ_ALU_REMAINDER_EN
    logic [WIDTH-1:0]   rem_step;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        busy       = 1'b0;
        op_start   = encode_op(op_sel);
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     (busy && (op_q == OP_DIV)),
        .dividend (x),
        .divisor  (y),
        .quotient (quo_step)
`ifdef SEQ_ALU_REMAINDER_EN
        ,
        .remainder(rem_step)
`endif
    );

    // Product after the current iteration; the final iteration's value is
    // committed directly so mul/div finish on the same edge as the last step.
    assign prod_step = mplier[0] ? (prod + mcand) : prod;

    always_comb begin
        res_final = '0;
        case (op_q)
            OP_ADD:  res_final = RES_W'(x_q) + RES_W'(y_q);
            OP_SUB:  res_final = RES_W'(x_q) - RES_W'(y_q);
            OP_MUL:  res_final = RES_W'(prod_step);
            OP_DIV:  res_final = (y_q == '0) ? '1 : RES_W'(quo_step);
            default: res_final = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_ADD;
            x_q      <= '0;
            y_q      <= '0;
            cnt      <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            result   <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            neg      <= 1'b0;
`ifdef SEQ_ALU_REMAINDER_EN
            remainder <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                x_q      <= x;
                y_q      <= y;
                op_q     <= op_start;
                cnt      <= ((op_start == OP_MUL) || (op_start == OP_DIV)) ?
                            CNT_W'(WIDTH) : CNT_W'(1);
                prod     <= '0;
                mcand    <= {{WIDTH{1'b0}}, x};
                mplier   <= y;
                div_zero <= 1'b0;
                neg      <= 1'b0;
            end else if (state == CALC) begin
                cnt <= cnt - CNT_W'(1);
                if (op_q == OP_MUL) begin
                    prod   <= prod_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
                if (last) begin
                    result   <= res_final;
                    done     <= 1'b1;
                    div_zero <= (op_q == OP_DIV) && (y_q == '0);
                    neg      <= (op_q == OP_SUB) && res_final[RES_W-1];
`ifdef SEQ_ALU_REMAINDER_EN
                    remainder <= (op_q == OP_DIV) ? rem_step : '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu
// Scoreboard bench for seq_alu (WIDTH=6, RES_W=13). Expected results are
// computed from integer arithmetic when each start is driven and compared
// when done pulses.
// ----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int WIDTH = 6;
    localparam int RES_W = 13;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       op_sel;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [RES_W-1:0] result;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             neg;
`ifdef SEQ_ALU_REMAINDER_EN
    logic [WIDTH-1:0] remainder;
`endif

    seq_alu #(.WIDTH(WIDTH), .RES_W(RES_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_sel   (op_sel),
        .x        (x),
        .y        (y),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .neg      (neg)
`ifdef SEQ_ALU_REMAINDER_EN
        ,
        .remainder(remainder)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int dz;
        int ng;
        int rem;
        int start_edge;
        int lat;
        int busy_n;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] os, input int xa, input int ya);
        exp_t e;
        e.res = 0; e.dz = 0; e.ng = 0; e.rem = 0;
        e.lat = 2; e.busy_n = 1; e.start_edge = 0;
        if (os[3]) begin
            e.res = xa + ya;
        end else if (os[2]) begin
            e.res = (xa - ya) & 32'h1FFF;
            e.ng  = (xa < ya) ? 1 : 0;
        end else if (os[1]) begin
            e.lat = WIDTH + 1; e.busy_n = WIDTH;
            if (ya == 0) begin
                e.res = 32'h1FFF; e.dz = 1; e.rem = xa;
            end else begin
                e.res = xa / ya; e.rem = xa % ya;
            end
        end else if (os[0]) begin
            e.lat = WIDTH + 1; e.busy_n = WIDTH;
            e.res = xa * ya;
        end
        return e;
    endfunction

    // Call at a negedge: start is sampled on the next rising edge.
    task automatic issue(input logic [3:0] os, input int xa, input int ya);
        exp_t e;
        op_sel = os;
        x      = WIDTH'(xa);
        y      = WIDTH'(ya);
        start  = 1'b1;
        e = model(os, xa, ya);
        e.start_edge = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_for_done();
        int i;
        i = 0;
        while (!done && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic wait_done();
        @(negedge clk);
        start = 1'b0;
        wait_for_done();
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", {31'b0, done}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", 32'(result), mon_e.res);
                    check("div_zero", {31'b0, div_zero}, mon_e.dz);
                    check("neg", {31'b0, neg}, mon_e.ng);
                    check("latency", cyc - mon_e.start_edge + 1, mon_e.lat);
                    check("busy_cycles", busy_cnt, mon_e.busy_n);
`ifdef SEQ_ALU_REMAINDER_EN
                    check("remainder", 32'(remainder), mon_e.rem);
`endif
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw_done;
        reset  = 1'b1;
        start  = 1'b0;
        op_sel = 4'b0000;
        x      = '0;
        y      = '0;
        repeat (3) @(negedge clk);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_div_zero", {31'b0, div_zero}, 32'd0);
        check("rst_neg", {31'b0, neg}, 32'd0);
`ifdef SEQ_ALU_REMAINDER_EN
        check("rst_remainder", 32'(remainder), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // add
        issue(4'b1000, 45, 18);
        @(negedge clk);
        start = 1'b0;
        check("busy_add", {31'b0, busy}, 32'd1);
        wait_for_done();
        @(negedge clk);

        // sub wins over div by priority
        issue(4'b0110, 5, 9);
        wait_done();
        @(negedge clk);

        // mul
        issue(4'b0001, 63, 63);
        wait_done();
        @(negedge clk);

        // div, then divide by zero
        issue(4'b0010, 50, 7);
        wait_done();
        @(negedge clk);
        issue(4'b0010, 9, 0);
        wait_done();
        @(negedge clk);

        // op NONE; div_zero must clear at the accepted start
        issue(4'b0000, 12, 3);
        @(negedge clk);
        start = 1'b0;
        check("dz_cleared", {31'b0, div_zero}, 32'd0);
        wait_for_done();
        @(negedge clk);

        // all bits set -> add
        issue(4'b1111, 63, 63);
        wait_done();
        @(negedge clk);

        // start while busy is ignored, then back-to-back start in done cycle
        issue(4'b0001, 13, 11);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        op_sel = 4'b1000;
        x      = 6'd1;
        y      = 6'd1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignore", {31'b0, busy}, 32'd1);
        wait_for_done();
        issue(4'b0100, 3, 10);
        wait_done();
        @(negedge clk);

        // random mix
        for (int i = 0; i < 24; i++) begin
            issue(4'($urandom_range(0, 15)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            wait_done();
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);

        // reset in the third CALC cycle of a multiply
        op_sel = 4'b0001;
        x      = 6'd63;
        y      = 6'd62;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_div_zero", {31'b0, div_zero}, 32'd0);
        check("abort_neg", {31'b0, neg}, 32'd0);
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("abort_no_done", saw_done, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
